// File: rtl/mem_bist_ctrl.sv
// March C- BIST engine for a FIFO RAM wrapper: walks six march elements over the
// RAM through its bist_* port and latches pass/fail plus first-failure diagnostics.
module mem_bist_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_syndrome,
    output logic              bist_en,
    output logic              bist_rd_en,
    output logic              bist_wr_en,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_wr_data,
    input  logic [DATA_W-1:0] bist_rd_data
);
    localparam logic [DATA_W-1:0] PAT_P    = {(DATA_W/2){2'b01}};
    localparam logic [DATA_W-1:0] PAT_Q    = ~PAT_P;
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, CMP, WR, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        elem, elem_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              pass_n;
    logic [2:0]        fail_elem_n;
    logic [ADDR_W-1:0] fail_addr_n;
    logic [DATA_W-1:0] fail_syndrome_n;
    logic [RD_LAT:1]   rd_pipe;
    logic [RD_LAT:0]   vld_pipe;
    logic              down, addr_last, advance;
    logic [DATA_W-1:0] rd_exp, wr_pat;

    // vld_pipe[k] is set k cycles after a read strobe; data is valid at k = RD_LAT
    assign vld_pipe  = {rd_pipe, bist_rd_en};

    assign down      = (elem >= 3'd3);
    assign addr_last = down ? (addr == '0) : (addr == ADDR_TOP);
    assign rd_exp    = (elem == 3'd2 || elem == 3'd4) ? PAT_Q : PAT_P;
    assign wr_pat    = (elem == 3'd1 || elem == 3'd3) ? PAT_Q : PAT_P;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            elem          <= '0;
            addr          <= '0;
            pass          <= 1'b0;
            fail_elem     <= '0;
            fail_addr     <= '0;
            fail_syndrome <= '0;
            rd_pipe       <= '0;
        end else begin
            state         <= state_n;
            elem          <= elem_n;
            addr          <= addr_n;
            pass          <= pass_n;
            fail_elem     <= fail_elem_n;
            fail_addr     <= fail_addr_n;
            fail_syndrome <= fail_syndrome_n;
            rd_pipe       <= vld_pipe[RD_LAT-1:0];
        end
    end

    always_comb begin
        state_n         = state;
        elem_n          = elem;
        addr_n          = addr;
        pass_n          = pass;
        fail_elem_n     = fail_elem;
        fail_addr_n     = fail_addr;
        fail_syndrome_n = fail_syndrome;
        advance         = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n         = WR;
                    elem_n          = '0;
                    addr_n          = '0;
                    pass_n          = 1'b0;
                    fail_elem_n     = '0;
                    fail_addr_n     = '0;
                    fail_syndrome_n = '0;
                end
            end
            RD, WAIT: state_n = vld_pipe[RD_LAT-1] ? CMP : WAIT;
            CMP: begin
                if (vld_pipe[RD_LAT] && (bist_rd_data != rd_exp)) begin
                    pass_n          = 1'b0;
                    fail_elem_n     = elem;
                    fail_addr_n     = addr;
                    fail_syndrome_n = bist_rd_data ^ rd_exp;
                    state_n         = DONE;
                end else if (elem != 3'd5) begin
                    state_n = WR;
                end else begin
                    advance = 1'b1;
                end
            end
            WR:      advance = 1'b1;
            default: state_n = IDLE;
        endcase

        // Step to the next address, or roll into the next element at the sweep end
        if (advance) begin
            if (addr_last) begin
                if (elem == 3'd5) begin
                    state_n = DONE;
                    pass_n  = 1'b1;
                end else begin
                    elem_n  = elem + 3'd1;
                    addr_n  = (elem >= 3'd2) ? ADDR_TOP : '0;
                    state_n = RD;
                end
            end else begin
                addr_n  = down ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
                state_n = (elem == 3'd0) ? WR : RD;
            end
        end
    end

    assign busy         = (state == RD) || (state == WAIT) || (state == CMP) || (state == WR);
    assign done         = (state == DONE);
    assign bist_en      = busy;
    assign bist_rd_en   = (state == RD);
    assign bist_wr_en   = (state == WR);
    assign bist_addr    = busy ? addr : '0;
    assign bist_wr_data = bist_wr_en ? wr_pat : '0;
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (RD_LAT 1 and 2) on behavioural RAMs with
// injectable stuck-at faults, a vector table, hand sequences and a march-level model.
module tb_mem_bist_ctrl;
    localparam logic [63:0] P    = {32{2'b01}};
    localparam logic [63:0] Q    = ~P;
    localparam logic [63:0] JUNK = 64'hC3C3_0F0F_A5A5_9696;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start0 = 1'b0, start2 = 1'b0;
    logic        busy0, done0, pass0, en0, rd0, wr0;
    logic        busy2, done2, pass2, en2, rd2, wr2;
    logic [2:0]  fe0, fe2;
    logic [1:0]  fa0, fa2, addr0, addr2;
    logic [63:0] fs0, fs2, wd0, wd2, rdd0, rdd2;

    int checks = 0;
    int errors = 0;
    int prot_err = 0;

    always #5 clk = ~clk;

    mem_bist_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_elem(fe0), .fail_addr(fa0), .fail_syndrome(fs0), .bist_en(en0),
        .bist_rd_en(rd0), .bist_wr_en(wr0), .bist_addr(addr0), .bist_wr_data(wd0),
        .bist_rd_data(rdd0)
    );

    mem_bist_ctrl #(.DEPTH(4), .ADDR_W(2), .DATA_W(64), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_elem(fe2), .fail_addr(fa2), .fail_syndrome(fs2), .bist_en(en2),
        .bist_rd_en(rd2), .bist_wr_en(wr2), .bist_addr(addr2), .bist_wr_data(wd2),
        .bist_rd_data(rdd2)
    );

    // RAMs with stuck-at masks applied as a read is launched
    logic [63:0] sa0 [4];
    logic [63:0] sa1 [4];
    logic [63:0] mem0 [4];
    logic [63:0] mem2 [4];
    logic        rv0 = 1'b0;
    logic [1:0]  rv2 = 2'b00;
    logic [63:0] rq0, rq2a, rq2b;

    function automatic logic [63:0] flt(input logic [1:0] a, input logic [63:0] d);
        return (d & ~sa0[a]) | sa1[a];
    endfunction

    always @(posedge clk) begin
        if (wr0) mem0[addr0] <= wd0;
        rv0 <= rd0;
        rq0 <= flt(addr0, mem0[addr0]);
        if (wr2) mem2[addr2] <= wd2;
        rv2  <= {rv2[0], rd2};
        rq2a <= flt(addr2, mem2[addr2]);
        rq2b <= rq2a;
    end

    // Outside the valid read slot the RAM returns junk, so a mis-timed sample fails
    assign rdd0 = rv0 ? rq0 : JUNK;
    assign rdd2 = rv2[1] ? rq2b : JUNK;

    always @(negedge clk) begin
        if (en0 !== busy0 || (rd0 && wr0) || (!wr0 && wd0 !== 64'h0) || (!busy0 && (rd0 || wr0 || addr0 !== 2'd0))) prot_err++;
        if (en2 !== busy2 || (rd2 && wr2) || (!wr2 && wd2 !== 64'h0) || (!busy2 && (rd2 || wr2 || addr2 !== 2'd0))) prot_err++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 4; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start2 = v;
        else start0 = v;
    endtask

    // March C- as a list of per-element read/write patterns: 0 none, 1 P, 2 Q
    function automatic void model(input int lat, output int cyc, output bit p,
                                  output logic [2:0] fe, output logic [1:0] fa,
                                  output logic [63:0] fs);
        logic [63:0] m [4];
        int rd_op [6];
        int wr_op [6];
        int ad;
        bit stop;
        logic [63:0] ex, got;
        rd_op = '{0, 1, 2, 1, 2, 1};
        wr_op = '{1, 2, 1, 2, 1, 0};
        cyc = 0; p = 1'b1; fe = '0; fa = '0; fs = '0; stop = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < 4; i++) begin
                ad = (el >= 3) ? 3 - i : i;
                if (!stop && rd_op[el] != 0) begin
                    cyc += lat + 1;
                    ex  = (rd_op[el] == 1) ? P : Q;
                    got = flt(2'(ad), m[ad]);
                    if (got !== ex) begin
                        p = 1'b0; fe = 3'(el); fa = 2'(ad); fs = got ^ ex; stop = 1'b1;
                    end
                end
                if (!stop && wr_op[el] != 0) begin
                    cyc += 1;
                    m[ad] = (wr_op[el] == 1) ? P : Q;
                end
            end
        end
    endfunction

    // Start a test and count busy cycles until done; faults may be injected at busy cycle inj
    task automatic run(input bit s, input int inj, input logic [1:0] fadr,
                       input logic [63:0] m0, input logic [63:0] m1,
                       input int g1, input int g2, output int bcnt, output bit tout);
        int guard;
        guard = 0; bcnt = 0; tout = 1'b0;
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        forever begin
            if (s ? done2 : done0) break;
            if (guard > 400) begin
                tout = 1'b1;
                break;
            end
            if (s ? busy2 : busy0) begin
                bcnt++;
                if (bcnt == inj) begin
                    sa0[fadr] = m0;
                    sa1[fadr] = m1;
                end
                if (bcnt == g1 || bcnt == g2) set_start(s, 1'b1);
            end
            guard++;
            @(negedge clk);
            set_start(s, 1'b0);
        end
    endtask

    task automatic check_run(input string tag, input bit s, input int bcnt, input bit tout,
                             input int eb, input bit ep, input logic [2:0] ee,
                             input logic [1:0] ea, input logic [63:0] es);
        chk({tag, ".timeout"}, 64'(tout), 64'd0);
        chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(eb));
        chk({tag, ".done"}, 64'(s ? done2 : done0), 64'd1);
        chk({tag, ".pass"}, 64'(s ? pass2 : pass0), 64'(ep));
        chk({tag, ".fail_elem"}, 64'(s ? fe2 : fe0), 64'(ee));
        chk({tag, ".fail_addr"}, 64'(s ? fa2 : fa0), 64'(ea));
        chk({tag, ".fail_syndrome"}, s ? fs2 : fs0, es);
        @(negedge clk);
        chk({tag, ".done_held"}, 64'(s ? done2 : done0), 64'd1);
        clear_faults();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl0"}, 64'({busy0, done0, pass0, fe0, fa0, en0, rd0, wr0, addr0}), 64'd0);
        chk({tag, ".syn0"}, fs0, 64'd0);
        chk({tag, ".wd0"}, wd0, 64'd0);
        chk({tag, ".ctl2"}, 64'({busy2, done2, pass2, fe2, fa2, en2, rd2, wr2, addr2}), 64'd0);
        chk({tag, ".syn2"}, fs2, 64'd0);
    endtask

    typedef struct {
        bit          sel;
        int          inj;
        logic [1:0]  fadr;
        logic [63:0] m0, m1;
        int          g1, g2;
        int          eb;
        bit          ep;
        logic [2:0]  ee;
        logic [1:0]  ea;
        logic [63:0] es;
    } vec_t;

    function automatic vec_t mk(bit sel, int inj, logic [1:0] fadr, logic [63:0] m0,
                                logic [63:0] m1, int g1, int g2, int eb, bit ep,
                                logic [2:0] ee, logic [1:0] ea, logic [63:0] es);
        vec_t v;
        v.sel = sel; v.inj = inj; v.fadr = fadr; v.m0 = m0; v.m1 = m1; v.g1 = g1; v.g2 = g2;
        v.eb = eb; v.ep = ep; v.ee = ee; v.ea = ea; v.es = es;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl [12];
        int bcnt, cyc;
        bit tout, ep;
        logic [2:0] ee;
        logic [1:0] ea;
        logic [63:0] es, mask;
        int kind;
        bit s;
        logic [1:0] a;

        // inj 0 = fault present from the start; E2's up-sweep is the first Q read of addr 3
        tbl[0]  = mk(0, 0,  2'd0, 64'h0, 64'h0, 0, 0,  60, 1, 3'd0, 2'd0, 64'h0);
        tbl[1]  = mk(0, 0,  2'd0, 64'h0, 64'h0, 5, 30, 60, 1, 3'd0, 2'd0, 64'h0);
        tbl[2]  = mk(0, 0,  2'd2, 64'h20, 64'h0, 0, 0, 24, 0, 3'd2, 2'd2, 64'h20);
        tbl[3]  = mk(0, 0,  2'd3, 64'h0, 64'h1, 0, 0,  27, 0, 3'd2, 2'd3, 64'h1);
        tbl[4]  = mk(0, 0,  2'd0, 64'h0, 64'h2, 0, 0,  6,  0, 3'd1, 2'd0, 64'h2);
        tbl[5]  = mk(0, 0,  2'd1, 64'h1, 64'h0, 0, 0,  9,  0, 3'd1, 2'd1, 64'h1);
        tbl[6]  = mk(0, 0,  2'd0, 64'h8000_0000_0000_0000, 64'h0, 0, 0, 18, 0, 3'd2, 2'd0, 64'h8000_0000_0000_0000);
        tbl[7]  = mk(0, 28, 2'd3, 64'h0, 64'h2, 0, 0,  30, 0, 3'd3, 2'd3, 64'h2);
        tbl[8]  = mk(0, 40, 2'd2, 64'h2, 64'h0, 0, 0,  45, 0, 3'd4, 2'd2, 64'h2);
        tbl[9]  = mk(0, 52, 2'd0, 64'h1, 64'h0, 0, 0,  60, 0, 3'd5, 2'd0, 64'h1);
        tbl[10] = mk(1, 0,  2'd0, 64'h0, 64'h0, 0, 0,  80, 1, 3'd0, 2'd0, 64'h0);
        tbl[11] = mk(1, 0,  2'd2, 64'h20, 64'h0, 0, 0, 31, 0, 3'd2, 2'd2, 64'h20);

        clear_faults();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].inj == 0) begin
                sa0[tbl[i].fadr] = tbl[i].m0;
                sa1[tbl[i].fadr] = tbl[i].m1;
            end
            run(tbl[i].sel, tbl[i].inj, tbl[i].fadr, tbl[i].m0, tbl[i].m1, tbl[i].g1, tbl[i].g2, bcnt, tout);
            check_run($sformatf("vec%0d", i), tbl[i].sel, bcnt, tout, tbl[i].eb, tbl[i].ep, tbl[i].ee, tbl[i].ea, tbl[i].es);
        end

        // Reset at busy cycle 20 aborts the test without a done
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (19) @(negedge clk);
        chk("midreset.busy_before", 64'(busy0), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        reset = 1'b1;
        @(negedge clk);
        chk("midreset.idle_done", 64'(done0), 64'd0);
        run(0, -1, 2'd0, 64'h0, 64'h0, 0, 0, bcnt, tout);
        check_run("after_reset", 0, bcnt, tout, 60, 1, 3'd0, 2'd0, 64'h0);

        // Random single stuck-at faults with stray start pulses, judged by the march model
        for (int it = 0; it < 10; it++) begin
            s    = 1'($urandom_range(0, 1));
            a    = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            mask = 64'h1 << $urandom_range(0, 63);
            if (kind == 1) sa0[a] = mask;
            if (kind == 2) sa1[a] = mask;
            model(s ? 2 : 1, cyc, ep, ee, ea, es);
            run(s, -1, 2'd0, 64'h0, 64'h0, $urandom_range(1, cyc), 0, bcnt, tout);
            check_run($sformatf("rand%0d", it), s, bcnt, tout, cyc, ep, ee, ea, es);
        end

        chk("protocol_violations", 64'(prot_err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
